// File: rtl/masked_alu_pkg.sv
// Shared types and helpers for the masked ALU datapath.
//   mode_e    : operation select for the masked AND unit
//   num_rnd   : fresh random bits needed per lane per operation at order d
//   pair_idx  : lexicographic index of the unordered share pair (i, j)
package masked_alu_pkg;

   typedef enum logic [1:0] {
      MODE_AND  = 2'd0,
      MODE_ANDN = 2'd1,
      MODE_OR   = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   function automatic int num_rnd(input int d);
      return ((d + 1) * d) / 2;
   endfunction

   // Pairs are ordered (0,1),(0,2)..(0,n-1),(1,2).. ; row lo starts after
   // sum_{p<lo}(n-1-p) = lo*n - lo*(lo+1)/2 earlier pairs.
   function automatic int pair_idx(input int i, input int j, input int d);
      int lo;
      int hi;
      int n;
      n  = d + 1;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
   endfunction

endpackage

// File: rtl/dom_indep_lane.sv
// One bit lane of the DOM-independent masked AND.
//   clk, clr (sync clear), en (register enable)
//   a, b  : operand shares (already mode pre-processed)
//   r     : fresh randomness for this lane
//   c     : result shares, compressed from registered terms only
module dom_indep_lane
   import masked_alu_pkg::*;
#(
   parameter  int D = 1,
   localparam int N = D + 1,
   localparam int L = num_rnd(D)
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [L-1:0] r,
   output logic [N-1:0] c
);

   // term[i][i] is the inner-domain product, term[i][j] the remasked cross term.
   logic [N-1:0] term_d [N];
   logic [N-1:0] term_q [N];

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         if (i == j) begin : g_inner
            assign term_d[i][j] = a[i] & b[i];
         end else begin : g_cross
            // t_ij and t_ji reuse the same random bit so it cancels on unmasking.
            localparam int K = pair_idx(i, j, D);
            assign term_d[i][j] = (a[i] & b[j]) ^ r[K];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < N; i++) term_q[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < N; i++) term_q[i] <= term_d[i];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_out
      assign c[i] = ^term_q[i];
   end

endmodule

// File: rtl/dom_indep_pipe.sv
// Pipelined, handshaked DOM-independent masked AND/ANDN/OR unit.
//   clk, rst (sync, active high)
//   in_valid/in_ready, in_mode, port_a, port_b : operation input
//   rnd_valid/rnd_ready, port_r                : fresh randomness
//   out_valid/out_ready, port_c                : masked result (1-cycle latency)
module dom_indep_pipe
   import masked_alu_pkg::*;
#(
   parameter  int D         = 1,
   parameter  int BIT_WIDTH = 32,
   localparam int N         = D + 1,
   localparam int L         = num_rnd(D)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_mode,
   input  logic [N-1:0] port_a [BIT_WIDTH],
   input  logic [N-1:0] port_b [BIT_WIDTH],
   input  logic         rnd_valid,
   output logic         rnd_ready,
   input  logic [L-1:0] port_r [BIT_WIDTH],
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] port_c [BIT_WIDTH]
);

   mode_e mode;
   logic  accept;
   logic  inv_a0;
   logic  inv_b0;
   logic  out_inv_d;
   logic  out_inv_q;

   assign mode      = mode_e'(in_mode);
   assign in_ready  = !out_valid | out_ready;
   assign accept    = in_valid & rnd_valid & in_ready;
   assign rnd_ready = accept;

   // Inverting share 0 inverts the unmasked value; OR is done via De Morgan.
   always_comb begin
      inv_a0    = 1'b0;
      inv_b0    = 1'b0;
      out_inv_d = 1'b0;
      case (mode)
         MODE_ANDN: inv_b0 = 1'b1;
         MODE_OR: begin
            inv_a0    = 1'b1;
            inv_b0    = 1'b1;
            out_inv_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_inv_q <= 1'b0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_inv_q <= out_inv_d;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < BIT_WIDTH; g++) begin : g_lane
      logic [N-1:0] a_pp;
      logic [N-1:0] b_pp;
      logic [N-1:0] c_raw;

      assign a_pp = port_a[g] ^ {{(N-1){1'b0}}, inv_a0};
      assign b_pp = port_b[g] ^ {{(N-1){1'b0}}, inv_b0};

      dom_indep_lane #(.D(D)) u_lane (
         .clk (clk),
         .clr (rst),
         .en  (accept),
         .a   (a_pp),
         .b   (b_pp),
         .r   (port_r[g]),
         .c   (c_raw)
      );

      assign port_c[g] = c_raw ^ {{(N-1){1'b0}}, out_inv_q};
   end

endmodule

// File: tb/tb_dom_indep_pipe.sv
module tb_dom_indep_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // Instance 1: D=1, 4 lanes (N=2, L=1)
   logic       d1_in_valid, d1_in_ready, d1_rnd_valid, d1_rnd_ready;
   logic       d1_out_valid, d1_out_ready;
   logic [1:0] d1_mode;
   logic [1:0] d1_a [4];
   logic [1:0] d1_b [4];
   logic [0:0] d1_r [4];
   logic [1:0] d1_c [4];

   // Instance 2: D=2, 8 lanes (N=3, L=3)
   logic       d2_in_valid, d2_in_ready, d2_rnd_valid, d2_rnd_ready;
   logic       d2_out_valid, d2_out_ready;
   logic [1:0] d2_mode;
   logic [2:0] d2_a [8];
   logic [2:0] d2_b [8];
   logic [2:0] d2_r [8];
   logic [2:0] d2_c [8];

   dom_indep_pipe #(.D(1), .BIT_WIDTH(4)) u_d1 (
      .clk(clk), .rst(rst),
      .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_mode(d1_mode),
      .port_a(d1_a), .port_b(d1_b),
      .rnd_valid(d1_rnd_valid), .rnd_ready(d1_rnd_ready), .port_r(d1_r),
      .out_valid(d1_out_valid), .out_ready(d1_out_ready), .port_c(d1_c)
   );

   dom_indep_pipe #(.D(2), .BIT_WIDTH(8)) u_d2 (
      .clk(clk), .rst(rst),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_mode(d2_mode),
      .port_a(d2_a), .port_b(d2_b),
      .rnd_valid(d2_rnd_valid), .rnd_ready(d2_rnd_ready), .port_r(d2_r),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready), .port_c(d2_c)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   // Reference: plain boolean on unmasked values.
   function automatic logic [7:0] golden(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
      case (m)
         2'd1:    return a & ~b;
         2'd2:    return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic d1_load(input logic [3:0] a, input logic [3:0] b);
      logic [1:0] t;
      for (int g = 0; g < 4; g++) begin
         t = 2'($urandom); t[0] = a[g] ^ t[1]; d1_a[g] = t;
         t = 2'($urandom); t[0] = b[g] ^ t[1]; d1_b[g] = t;
         d1_r[g] = 1'($urandom);
      end
   endtask

   task automatic d2_load(input logic [7:0] a, input logic [7:0] b);
      logic [2:0] t;
      for (int g = 0; g < 8; g++) begin
         t = 3'($urandom); t[0] = a[g] ^ t[1] ^ t[2]; d2_a[g] = t;
         t = 3'($urandom); t[0] = b[g] ^ t[1] ^ t[2]; d2_b[g] = t;
         d2_r[g] = 3'($urandom);
      end
   endtask

   function automatic logic [3:0] d1_unmask();
      logic [3:0] v;
      for (int g = 0; g < 4; g++) v[g] = ^d1_c[g];
      return v;
   endfunction

   function automatic logic [7:0] d1_raw();
      return {d1_c[3], d1_c[2], d1_c[1], d1_c[0]};
   endfunction

   function automatic logic [7:0] d2_unmask();
      logic [7:0] v;
      for (int g = 0; g < 8; g++) v[g] = ^d2_c[g];
      return v;
   endfunction

   function automatic logic [23:0] d2_raw();
      logic [23:0] v;
      for (int g = 0; g < 8; g++) v[g*3 +: 3] = d2_c[g];
      return v;
   endfunction

   typedef struct {
      logic [1:0] mode;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   logic [7:0]  raw0, raw1, raw_hold;
   logic [3:0]  op2_a, op2_b;
   logic [1:0]  op2_m;
   logic [7:0]  q_exp [$];
   logic [7:0]  exp_v, ra, rb;
   bit          exp_ov, exp_rdy, acc;
   int          acc_ops, cyc;

   initial begin
      vecs[0] = '{2'd0, 4'hC, 4'hA, 4'h8};
      vecs[1] = '{2'd1, 4'hC, 4'hA, 4'h4};
      vecs[2] = '{2'd2, 4'hC, 4'hA, 4'hE};
      vecs[3] = '{2'd3, 4'hC, 4'hA, 4'h8};
      vecs[4] = '{2'd0, 4'hF, 4'hF, 4'hF};
      vecs[5] = '{2'd1, 4'hF, 4'h0, 4'hF};
      vecs[6] = '{2'd2, 4'h0, 4'h0, 4'h0};
      vecs[7] = '{2'd1, 4'h0, 4'hF, 4'h0};
      vecs[8] = '{2'd2, 4'h5, 4'hA, 4'hF};
      vecs[9] = '{2'd0, 4'h5, 4'hA, 4'h0};

      rst = 1'b1;
      d1_in_valid = 0; d1_rnd_valid = 0; d1_out_ready = 1; d1_mode = 0;
      d2_in_valid = 0; d2_rnd_valid = 0; d2_out_ready = 1; d2_mode = 0;
      d1_load(4'h0, 4'h0);
      d2_load(8'h0, 8'h0);
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_d1_out_valid", d1_out_valid, 0);
      check("rst_d1_in_ready",  d1_in_ready,  1);
      check("rst_d1_rnd_ready", d1_rnd_ready, 0);
      check("rst_d1_port_c",    d1_raw(),     0);
      check("rst_d2_out_valid", d2_out_valid, 0);
      check("rst_d2_port_c",    d2_raw(),     0);
      rst = 1'b0;
      @(negedge clk);

      // Table vectors, back-to-back
      for (int i = 0; i < NV; i++) begin
         d1_mode = vecs[i].mode;
         d1_load(vecs[i].a, vecs[i].b);
         d1_in_valid = 1; d1_rnd_valid = 1;
         #1;
         check($sformatf("tbl%0d_rnd_ready", i), d1_rnd_ready, 1);
         @(negedge clk);
         check($sformatf("tbl%0d_out_valid", i), d1_out_valid, 1);
         check($sformatf("tbl%0d_result", i),    d1_unmask(),  vecs[i].exp);
      end
      d1_in_valid = 0; d1_rnd_valid = 0;
      @(negedge clk);
      check("drain_out_valid", d1_out_valid, 0);

      // Same operand shares, different r -> different result shares
      for (int m = 0; m < 3; m++) begin
         d1_mode = 2'(m);
         d1_load(4'hC, 4'hA);
         for (int g = 0; g < 4; g++) d1_r[g] = 1'b0;
         d1_in_valid = 1; d1_rnd_valid = 1;
         @(negedge clk);
         raw0 = d1_raw();
         check($sformatf("rdiff%0d_res0", m), d1_unmask(), golden(2'(m), 8'hC, 8'hA));
         for (int g = 0; g < 4; g++) d1_r[g] = 1'b1;
         @(negedge clk);
         raw1 = d1_raw();
         check($sformatf("rdiff%0d_res1", m), d1_unmask(), golden(2'(m), 8'hC, 8'hA));
         check($sformatf("rdiff%0d_shares_differ", m), raw0 != raw1, 1);
         d1_in_valid = 0; d1_rnd_valid = 0;
         @(negedge clk);
      end

      // Backpressure: 3 stalled cycles, then back-to-back accept
      d1_mode = 2'd0; d1_load(4'hC, 4'hA);
      d1_in_valid = 1; d1_rnd_valid = 1; d1_out_ready = 0;
      @(negedge clk);
      check("bp_out_valid", d1_out_valid, 1);
      check("bp_result",    d1_unmask(),  4'h8);
      raw_hold = d1_raw();
      op2_m = 2'd2; op2_a = 4'h3; op2_b = 4'h4;
      d1_mode = op2_m; d1_load(op2_a, op2_b);
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp%0d_in_ready", k),  d1_in_ready,  0);
         check($sformatf("bp%0d_rnd_ready", k), d1_rnd_ready, 0);
         @(negedge clk);
         check($sformatf("bp%0d_out_valid", k), d1_out_valid, 1);
         check($sformatf("bp%0d_stable", k),    d1_raw(),     raw_hold);
      end
      d1_out_ready = 1;
      #1;
      check("bp_release_in_ready",  d1_in_ready,  1);
      check("bp_release_rnd_ready", d1_rnd_ready, 1);
      @(negedge clk);
      check("bp_b2b_out_valid", d1_out_valid, 1);
      check("bp_b2b_result",    d1_unmask(),  golden(op2_m, 8'(op2_a), 8'(op2_b)));
      d1_in_valid = 0; d1_rnd_valid = 0;
      @(negedge clk);
      check("bp_done_out_valid", d1_out_valid, 0);

      // Randomness starvation
      d1_mode = 2'd1; d1_load(4'h9, 4'h1);
      d1_in_valid = 1; d1_rnd_valid = 0;
      for (int k = 0; k < 2; k++) begin
         #1;
         check($sformatf("starve%0d_rnd_ready", k), d1_rnd_ready, 0);
         @(negedge clk);
         check($sformatf("starve%0d_out_valid", k), d1_out_valid, 0);
      end
      d1_rnd_valid = 1;
      #1;
      check("starve_rnd_ready", d1_rnd_ready, 1);
      @(negedge clk);
      check("starve_out_valid", d1_out_valid, 1);
      check("starve_result",    d1_unmask(),  4'h8);
      d1_in_valid = 0; d1_rnd_valid = 0;
      @(negedge clk);

      // Reset while holding a result
      d1_mode = 2'd2; d1_load(4'hC, 4'hA);
      d1_in_valid = 1; d1_rnd_valid = 1; d1_out_ready = 0;
      @(negedge clk);
      check("mrst_pre_out_valid", d1_out_valid, 1);
      d1_in_valid = 0; d1_rnd_valid = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_out_valid", d1_out_valid, 0);
      check("mrst_port_c",    d1_raw(),     0);
      check("mrst_in_ready",  d1_in_ready,  1);
      d1_out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("mrst_no_stale%0d", k), d1_out_valid, 0);
      end

      // Randomized D=2 traffic against the queue model
      exp_ov = 0; acc_ops = 0; cyc = 0;
      while (acc_ops < 1000 && cyc < 20000) begin
         cyc++;
         check("rand_out_valid", d2_out_valid, exp_ov);
         d2_out_ready = ($urandom_range(3) != 0);
         if (exp_ov && d2_out_ready) begin
            if (q_exp.size() == 0) check("rand_queue_nonempty", 0, 1);
            else begin
               exp_v = q_exp.pop_front();
               check("rand_result", d2_unmask(), exp_v);
            end
         end
         d2_in_valid  = ($urandom_range(3) != 0);
         d2_rnd_valid = ($urandom_range(3) != 0);
         ra = 8'($urandom); rb = 8'($urandom);
         d2_mode = 2'($urandom_range(3));
         d2_load(ra, rb);
         exp_rdy = !exp_ov || d2_out_ready;
         acc = d2_in_valid && d2_rnd_valid && exp_rdy;
         #1;
         check("rand_in_ready",  d2_in_ready,  exp_rdy);
         check("rand_rnd_ready", d2_rnd_ready, acc);
         if (acc) begin
            q_exp.push_back(golden(d2_mode, ra, rb));
            exp_ov = 1;
            acc_ops++;
         end else if (d2_out_ready) begin
            exp_ov = 0;
         end
         @(negedge clk);
      end
      check("rand_ops_done", acc_ops, 1000);
      d2_in_valid = 0; d2_rnd_valid = 0; d2_out_ready = 1;
      check("rand_final_out_valid", d2_out_valid, exp_ov);
      if (exp_ov && q_exp.size() != 0) begin
         exp_v = q_exp.pop_front();
         check("rand_final_result", d2_unmask(), exp_v);
      end
      @(negedge clk);
      check("rand_drained", d2_out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
